// File: rtl/match_pkg.sv
// match_pkg: shared sizes, FSM state type and lane adder
// for the match accumulator slice.
package match_pkg;

  localparam int NCAND  = 16;
  localparam int NLANE  = 4;
  localparam int LANE_W = 14;
  localparam int CAND_W = $clog2(NCAND);
  localparam int BUS_W  = NLANE * LANE_W;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    SCAN,
    RESULT
  } match_state_e;

  // 4 x 14-bit lanes always fit in 16 bits.
  function automatic logic [15:0] lane_sum(
    input logic [BUS_W-1:0] bus
  );
    logic [15:0] s;
    s = '0;
    for (int k = 0; k < NLANE; k++)
      s = s + 16'(bus[k*LANE_W +: LANE_W]);
    return s;
  endfunction

endpackage

// File: rtl/match_argmin.sv
// match_argmin: serial running-minimum tracker.
// Ports: en/first/idx/score in; best_idx/best_score out.
module match_argmin
  import match_pkg::*;
#(
  parameter int IW = CAND_W,
  parameter int SW = 26
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 first,
  input  logic [IW-1:0]        idx,
  input  logic signed [SW-1:0] score,
  output logic [IW-1:0]        best_idx,
  output logic signed [SW-1:0] best_score
);

  // Strict less-than keeps the lowest index on ties.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_idx   <= '0;
      best_score <= '0;
    end else if (en && (first || score < best_score)) begin
      best_idx   <= idx;
      best_score <= score;
    end
  end

endmodule

// File: rtl/match_accum.sv
// match_accum: per-candidate gg/fg accumulation over ROWS
// passes, then serial argmin of gg-2*fg with valid/ready out.
// Ports: in_valid/in_ready/in_cand/in_wg/in_wfg beat input;
// out_valid/out_ready/out_idx/out_score result; seq_err
// sticky order error. MATCH_ACCUM_SAT_EN: saturating adds
// plus sticky acc_sat output.
module match_accum
  import match_pkg::*;
#(
  parameter int ROWS  = 8,
  parameter int ACC_W = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CAND_W-1:0]       in_cand,
  input  logic [BUS_W-1:0]        in_wg,
  input  logic [BUS_W-1:0]        in_wfg,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CAND_W-1:0]       out_idx,
  output logic signed [ACC_W+1:0] out_score,
  output logic                    seq_err
`ifdef MATCH_ACCUM_SAT_EN
  ,
  output logic                    acc_sat
`endif
);

  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int SW  = ACC_W + 2;

  match_state_e state;

  logic [CAND_W-1:0] cand_cnt;
  logic [CAND_W-1:0] cand_nxt;
  logic [RW-1:0]     row_cnt;
  logic              cand_last;
  logic              row_last;
  logic              fire;

  logic [ACC_W-1:0] acc_gg [NCAND];
  logic [ACC_W-1:0] acc_fg [NCAND];

  logic [15:0]      sg;
  logic [15:0]      sfg;
  logic [ACC_W-1:0] nxt_gg;
  logic [ACC_W-1:0] nxt_fg;

  logic signed [SW-1:0] score;

  assign fire      = in_valid && in_ready;
  assign cand_last = (cand_cnt == CAND_W'(NCAND - 1));
  assign row_last  = (row_cnt == RW'(ROWS - 1));
  assign cand_nxt  = cand_last ? '0 : cand_cnt + 1'b1;

  assign sg  = lane_sum(in_wg);
  assign sfg = lane_sum(in_wfg);

`ifdef MATCH_ACCUM_SAT_EN
  localparam int AW1 = ACC_W + 1;
  logic [ACC_W:0] add_gg;
  logic [ACC_W:0] add_fg;
  logic           sat_hit;

  always_comb begin
    add_gg  = {1'b0, acc_gg[cand_cnt]} + AW1'(sg);
    add_fg  = {1'b0, acc_fg[cand_cnt]} + AW1'(sfg);
    nxt_gg  = ACC_W'(sg);
    nxt_fg  = ACC_W'(sfg);
    sat_hit = 1'b0;
    if (row_cnt != '0) begin
      nxt_gg  = add_gg[ACC_W] ? '1 : add_gg[ACC_W-1:0];
      nxt_fg  = add_fg[ACC_W] ? '1 : add_fg[ACC_W-1:0];
      sat_hit = add_gg[ACC_W] || add_fg[ACC_W];
    end
  end
`else
  always_comb begin
    nxt_gg = ACC_W'(sg);
    nxt_fg = ACC_W'(sfg);
    if (row_cnt != '0) begin
      nxt_gg = acc_gg[cand_cnt] + ACC_W'(sg);
      nxt_fg = acc_fg[cand_cnt] + ACC_W'(sfg);
    end
  end
`endif

  // Row 0 overwrites, so the arrays need no reset.
  always_ff @(posedge clk) begin
    if (fire) begin
      acc_gg[cand_cnt] <= nxt_gg;
      acc_fg[cand_cnt] <= nxt_fg;
    end
  end

  // cand_cnt doubles as the scan pointer.
  assign score = $signed({2'b00, acc_gg[cand_cnt]})
               - $signed({1'b0, acc_fg[cand_cnt], 1'b0});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      cand_cnt  <= '0;
      row_cnt   <= '0;
      seq_err   <= 1'b0;
`ifdef MATCH_ACCUM_SAT_EN
      acc_sat   <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          state    <= ACCUM;
          in_ready <= 1'b1;
        end
        ACCUM: begin
          if (fire) begin
            if (in_cand != cand_cnt)
              seq_err <= 1'b1;
`ifdef MATCH_ACCUM_SAT_EN
            if (sat_hit)
              acc_sat <= 1'b1;
`endif
            cand_cnt <= cand_nxt;
            if (cand_last) begin
              if (row_last) begin
                row_cnt  <= '0;
                state    <= SCAN;
                in_ready <= 1'b0;
              end else begin
                row_cnt <= row_cnt + 1'b1;
              end
            end
          end
        end
        SCAN: begin
          cand_cnt <= cand_nxt;
          if (cand_last) begin
            state     <= RESULT;
            out_valid <= 1'b1;
          end
        end
        RESULT: begin
          if (out_ready) begin
            state     <= ACCUM;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  match_argmin #(
    .IW(CAND_W),
    .SW(SW)
  ) u_argmin (
    .clk       (clk),
    .rst       (rst),
    .en        (state == SCAN),
    .first     (cand_cnt == '0),
    .idx       (cand_cnt),
    .score     (score),
    .best_idx  (out_idx),
    .best_score(out_score)
  );

endmodule

// File: tb/tb_match_accum.sv
// tb_match_accum: directed self-checking bench for
// match_accum (main instance plus an ACC_W=16 overflow one).
module tb_match_accum;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [3:0]         in_cand;
  logic [55:0]        in_wg;
  logic [55:0]        in_wfg;
  logic               out_valid;
  logic               out_ready;
  logic [3:0]         out_idx;
  logic signed [25:0] out_score;
  logic               seq_err;

  logic               ov_rst;
  logic               ov_in_valid;
  logic               ov_in_ready;
  logic [3:0]         ov_in_cand;
  logic [55:0]        ov_in_wg;
  logic               ov_out_valid;
  logic               ov_out_ready;
  logic [3:0]         ov_out_idx;
  logic signed [17:0] ov_out_score;
  logic               ov_seq_err;

`ifdef MATCH_ACCUM_SAT_EN
  logic acc_sat;
  logic ov_acc_sat;
`endif

  int n_pass;
  int n_tot;
  int gv [16];
  int fv [16];

  match_accum #(.ROWS(8), .ACC_W(24)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_cand  (in_cand),
    .in_wg    (in_wg),
    .in_wfg   (in_wfg),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_idx  (out_idx),
    .out_score(out_score),
    .seq_err  (seq_err)
`ifdef MATCH_ACCUM_SAT_EN
    ,
    .acc_sat  (acc_sat)
`endif
  );

  match_accum #(.ROWS(8), .ACC_W(16)) u_ov (
    .clk      (clk),
    .rst      (ov_rst),
    .in_valid (ov_in_valid),
    .in_ready (ov_in_ready),
    .in_cand  (ov_in_cand),
    .in_wg    (ov_in_wg),
    .in_wfg   (ov_in_wg),
    .out_valid(ov_out_valid),
    .out_ready(ov_out_ready),
    .out_idx  (ov_out_idx),
    .out_score(ov_out_score),
    .seq_err  (ov_seq_err)
`ifdef MATCH_ACCUM_SAT_EN
    ,
    .acc_sat  (ov_acc_sat)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [55:0] fill(input int v);
    logic [13:0] l;
    l = 14'(v);
    return {l, l, l, l};
  endfunction

  task automatic set_data(input int g, input int f);
    for (int i = 0; i < 16; i++) begin
      gv[i] = g;
      fv[i] = f;
    end
  endtask

  // Offers nbeats in candidate/row order; one beat can carry
  // a wrong candidate tag.
  task automatic send_frame(input int nbeats, input int bad_row,
                            input int bad_cand,
                            input logic [3:0] bad_val);
    int sent;
    int w;
    sent = 0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 16; c++) begin
        if (sent < nbeats) begin
          in_valid = 1'b1;
          in_cand  = (r == bad_row && c == bad_cand) ?
                     bad_val : 4'(c);
          in_wg    = fill(gv[c]);
          in_wfg   = fill(fv[c]);
          w = 0;
          @(negedge clk);
          while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
          end
          if (!in_ready) begin
            n_tot++;
            $display("FAIL beat_accept: in_ready=0 at beat %0d, required 1",
                     sent);
          end
          @(posedge clk);
          #1;
          sent++;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  // cyc is the cycle index (1 = first cycle after the last
  // accepted beat) in which out_valid is first seen high.
  task automatic wait_result(output int cyc);
    cyc = 1;
    while (!out_valid && cyc < 60) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ov_rst = 1'b1;
    in_valid = 1'b0;
    in_cand = '0;
    in_wg = '0;
    in_wfg = '0;
    out_ready = 1'b0;
    ov_in_valid = 1'b0;
    ov_in_cand = '0;
    ov_in_wg = '0;
    ov_out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tot++;
    if (in_ready !== 1'b0)
      $display("FAIL reset_in_ready: got %b, required 0", in_ready);
    else n_pass++;
    n_tot++;
    if (out_valid !== 1'b0)
      $display("FAIL reset_out_valid: got %b, required 0", out_valid);
    else n_pass++;
    n_tot++;
    if (out_idx !== 4'd0)
      $display("FAIL reset_out_idx: got %0d, required 0", out_idx);
    else n_pass++;
    n_tot++;
    if (out_score !== 26'sd0)
      $display("FAIL reset_out_score: got %0d, required 0", out_score);
    else n_pass++;
    n_tot++;
    if (seq_err !== 1'b0)
      $display("FAIL reset_seq_err: got %b, required 0", seq_err);
    else n_pass++;
    rst = 1'b0;
    ov_rst = 1'b0;
    @(posedge clk);
    #1;
    n_tot++;
    if (in_ready !== 1'b1)
      $display("FAIL first_ready: got %b, required 1", in_ready);
    else n_pass++;
    n_tot++;
    if (ov_in_ready !== 1'b1)
      $display("FAIL ov_first_ready: got %b, required 1", ov_in_ready);
    else n_pass++;
  endtask

  task automatic test_single();
    int cyc;
    set_data(1, 0);
    fv[5] = 1;
    send_frame(128, -1, 0, 4'd0);
    n_tot++;
    if (in_ready !== 1'b0)
      $display("FAIL single_ready_drop: got %b, required 0", in_ready);
    else n_pass++;
    wait_result(cyc);
    n_tot++;
    if (out_valid !== 1'b1 || cyc != 17)
      $display("FAIL single_latency: valid=%b cycle=%0d, required 1 at 17",
               out_valid, cyc);
    else n_pass++;
    n_tot++;
    if (out_idx !== 4'd5)
      $display("FAIL single_idx: got %0d, required 5", out_idx);
    else n_pass++;
    n_tot++;
    if (out_score !== -26'sd32)
      $display("FAIL single_score: got %0d, required -32", out_score);
    else n_pass++;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    n_tot++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL single_accept: valid=%b ready=%b, required 0/1",
               out_valid, in_ready);
    else n_pass++;
    n_tot++;
    if (seq_err !== 1'b0)
      $display("FAIL single_seq_err: got %b, required 0", seq_err);
    else n_pass++;
  endtask

  task automatic test_tie();
    int cyc;
    set_data(2, 0);
    gv[3] = 1;
    gv[9] = 1;
    send_frame(128, -1, 0, 4'd0);
    wait_result(cyc);
    n_tot++;
    if (out_valid !== 1'b1)
      $display("FAIL tie_valid: got %b, required 1", out_valid);
    else n_pass++;
    n_tot++;
    if (out_idx !== 4'd3)
      $display("FAIL tie_idx: got %0d, required 3", out_idx);
    else n_pass++;
    n_tot++;
    if (out_score !== 26'sd32)
      $display("FAIL tie_score: got %0d, required 32", out_score);
    else n_pass++;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int cyc;
    set_data(5, 0);
    fv[12] = 2;
    send_frame(128, -1, 0, 4'd0);
    wait_result(cyc);
    in_valid = 1'b1;
    in_cand = 4'd0;
    in_wg = fill(9);
    in_wfg = fill(9);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      n_tot++;
      if (out_valid !== 1'b1 || out_idx !== 4'd12 ||
          out_score !== 26'sd32 || in_ready !== 1'b0)
        $display("FAIL bp_hold[%0d]: v=%b idx=%0d score=%0d rdy=%b, required 1/12/32/0",
                 i, out_valid, out_idx, out_score, in_ready);
      else n_pass++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    set_data(2, 0);
    send_frame(128, -1, 0, 4'd0);
    wait_result(cyc);
    n_tot++;
    if (out_valid !== 1'b1 || cyc != 17)
      $display("FAIL bp_frame2_latency: valid=%b cycle=%0d, required 1 at 17",
               out_valid, cyc);
    else n_pass++;
    n_tot++;
    if (out_idx !== 4'd0)
      $display("FAIL bp_frame2_idx: got %0d, required 0", out_idx);
    else n_pass++;
    n_tot++;
    if (out_score !== 26'sd64)
      $display("FAIL bp_frame2_score: got %0d, required 64", out_score);
    else n_pass++;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_seq_err();
    int cyc;
    set_data(3, 0);
    fv[6] = 1;
    send_frame(128, 2, 6, 4'd7);
    n_tot++;
    if (seq_err !== 1'b1)
      $display("FAIL seq_err_set: got %b, required 1", seq_err);
    else n_pass++;
    wait_result(cyc);
    n_tot++;
    if (out_idx !== 4'd6 || out_score !== 26'sd32)
      $display("FAIL seq_err_result: idx=%0d score=%0d, required 6/32",
               out_idx, out_score);
    else n_pass++;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tot++;
    if (seq_err !== 1'b1)
      $display("FAIL seq_err_sticky: got %b, required 1", seq_err);
    else n_pass++;
  endtask

  task automatic test_midreset();
    int cyc;
    set_data(1, 0);
    fv[2] = 3;
    send_frame(50, -1, 0, 4'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_tot++;
    if (in_ready !== 1'b0 || seq_err !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL midreset_clear: rdy=%b err=%b valid=%b, required 0/0/0",
               in_ready, seq_err, out_valid);
    else n_pass++;
    rst = 1'b0;
    @(posedge clk);
    #1;
    set_data(1, 0);
    fv[11] = 1;
    send_frame(128, -1, 0, 4'd0);
    wait_result(cyc);
    n_tot++;
    if (out_valid !== 1'b1 || cyc != 17)
      $display("FAIL midreset_latency: valid=%b cycle=%0d, required 1 at 17",
               out_valid, cyc);
    else n_pass++;
    n_tot++;
    if (out_idx !== 4'd11 || out_score !== -26'sd32)
      $display("FAIL midreset_result: idx=%0d score=%0d, required 11/-32",
               out_idx, out_score);
    else n_pass++;
    n_tot++;
    if (seq_err !== 1'b0)
      $display("FAIL midreset_seq_err: got %b, required 0", seq_err);
    else n_pass++;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  // 8 rows x 65532 per candidate in a 16-bit accumulator.
  task automatic test_overflow();
    int w;
    logic signed [17:0] exp_score;
`ifdef MATCH_ACCUM_SAT_EN
    exp_score = -18'sd65535;
`else
    exp_score = -18'sd65504;
`endif
    ov_in_wg = fill(16383);
    for (int b = 0; b < 128; b++) begin
      ov_in_valid = 1'b1;
      ov_in_cand = 4'(b % 16);
      w = 0;
      @(negedge clk);
      while (!ov_in_ready && w < 50) begin
        @(negedge clk);
        w++;
      end
      if (!ov_in_ready) begin
        n_tot++;
        $display("FAIL ov_beat_accept: in_ready=0 at beat %0d, required 1", b);
      end
      @(posedge clk);
      #1;
    end
    ov_in_valid = 1'b0;
    w = 0;
    while (!ov_out_valid && w < 60) begin
      @(posedge clk);
      #1;
      w++;
    end
    n_tot++;
    if (ov_out_valid !== 1'b1)
      $display("FAIL ov_valid: got %b, required 1", ov_out_valid);
    else n_pass++;
    n_tot++;
    if (ov_out_idx !== 4'd0 || ov_out_score !== exp_score)
      $display("FAIL ov_result: idx=%0d score=%0d, required 0/%0d",
               ov_out_idx, ov_out_score, exp_score);
    else n_pass++;
`ifdef MATCH_ACCUM_SAT_EN
    n_tot++;
    if (ov_acc_sat !== 1'b1)
      $display("FAIL ov_acc_sat: got %b, required 1", ov_acc_sat);
    else n_pass++;
    n_tot++;
    if (acc_sat !== 1'b0)
      $display("FAIL main_acc_sat: got %b, required 0", acc_sat);
    else n_pass++;
`endif
  endtask

  initial begin
    n_pass = 0;
    n_tot = 0;
    test_reset();
    test_single();
    test_tie();
    test_backpressure();
    test_seq_err();
    test_midreset();
    test_overflow();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
